reg_bank_timer_alarm: RTL and testbench
=======================================

Name: reg_bank_timer_alarm

Overview:
- Parametrised successor of the clock/date/timer register bank. Holds N_CH data channels, each loaded from either the RTC read path or the user-edit counter path.
- A countdown-timer supervisor compares elapsed RTC timer fields against the programmed target on all three fields (hour included). It runs a four-state alarm FSM with an optional auto-timeout.
- Sits between the RTC interface/edit counters and the VGA/RTC write-back logic.

Parameters:
DATA_W, 8, width of every channel (BCD byte per field)
N_CH, 9, number of channels in the bank
TMR_SEG_IDX, 6, channel index of timer seconds
TMR_MIN_IDX, 7, channel index of timer minutes
TMR_HORA_IDX, 8, channel index of timer hours
ALARM_TIMEOUT, 0, clock cycles in ALARM before automatic return to IDLE; 0 = never

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
cs  input  N_CH  per-channel select: load from count_data
hold  input  N_CH  per-channel freeze
rtc_data  input  N_CH*DATA_W  packed RTC values, channel i at [i*DATA_W +: DATA_W]
count_data  input  N_CH*DATA_W  packed edit-counter values, same packing
cfg_sw  input  1  timer configuration switch
alarm_clear  input  1  user alarm acknowledge (level)
out_data  output  N_CH*DATA_W  registered channel contents, same packing
timer_view  output  3*DATA_W  VGA timer view {hora,min,seg}
show_count  output  1  1 = VGA shows edit-counter values
alarm_active  output  1  alarm state indicator
alarm_pulse  output  1  one-cycle strobe on ALARM entry

Behaviour:
- Reset: all channel registers 0; FSM = IDLE; done_q 0; timeout counter 0; alarm_pulse 0; show_count 1; alarm_active 0. Reset asserted mid-operation (any state) gives the same values immediately.
- Channel i, per edge, priority: cs[i] -> load count_data[i]; else hold[i] -> keep; else load rtc_data[i]. Latency 1 cycle. Channels are independent.
- Target T = count_data of the three timer channels. Elapsed E = rtc_data of the same channels.
- match = (E==T on all three fields) && (T != 0).
- done_q <= match && state==RUN && !alarm_active, registered.
- FSM states and outputs:
  - IDLE: show_count=1, alarm_active=0. Goes to CONF when cfg_sw=1.
  - CONF: show_count=1, alarm_active=0. Goes to RUN when cfg_sw=0.
  - RUN: show_count=0, alarm_active=0. Goes to ALARM when done_q=1. Goes to CONF when cfg_sw=1 (abort); abort wins over done_q.
  - ALARM: show_count=1, alarm_active=1. Goes to IDLE when alarm_clear=1, or when the timeout counter reaches ALARM_TIMEOUT-1 (only if ALARM_TIMEOUT>0). Both in the same cycle -> IDLE.
- State register, show_count and alarm_active are registered, decoded from the next state.
- Match timing: match present at edge k -> done_q=1 after edge k -> state=ALARM and alarm_active=1 after edge k+1.
- alarm_pulse: 1 for exactly the first cycle in ALARM; 0 otherwise.
- Timeout counter: width clog2(ALARM_TIMEOUT+1), min 1. Cleared on every entry to ALARM. Increments each cycle in ALARM. Saturates and does not wrap.
- alarm_clear outside ALARM: ignored.
- timer_view = show_count ? T : current out_data of the timer channels (combinational mux).
- T=0 never raises the alarm.

Test Plan:
- Bank load: cs[3]=1, count_data ch3=8'h15 -> out ch3=8'h15 one edge later. Then cs=0, hold[3]=1 with rtc ch3=8'h22 -> out ch3 stays 8'h15. Release hold -> 8'h22.
- Timer alarm: T={00,01,30}, cfg_sw 1->0 -> RUN, show_count=0. Drive E={00,01,30} -> alarm_active=1 two edges later, alarm_pulse high one cycle. alarm_clear=1 -> IDLE, show_count=1.
- Hour check: T={01,00,00}, E={00,00,00} -> no alarm. E={01,00,00} -> alarm.
- Zero target: T=0, E=0 in RUN for 100 cycles -> alarm_active stays 0.
- Timeout: ALARM_TIMEOUT=4, enter ALARM, no clear -> IDLE after exactly 4 cycles in ALARM. alarm_clear during IDLE -> no effect.
- Abort and reset: cfg_sw=1 in the same cycle done_q=1 -> CONF, no alarm. Assert reset in ALARM -> alarm_active=0 and out_data=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_bank_timer_alarm.sv
// rtl/reg_bank_timer_alarm.sv - channel register bank with countdown-timer alarm supervisor
// Channels load from edit counters or RTC; timer fields drive a four-state alarm FSM.
module reg_bank_timer_alarm #(
  parameter int DATA_W        = 8,
  parameter int N_CH          = 9,
  parameter int TMR_SEG_IDX   = 6,
  parameter int TMR_MIN_IDX   = 7,
  parameter int TMR_HORA_IDX  = 8,
  parameter int ALARM_TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          cs,
  input  logic [N_CH-1:0]          hold,
  input  logic [N_CH*DATA_W-1:0]   rtc_data,
  input  logic [N_CH*DATA_W-1:0]   count_data,
  input  logic                     cfg_sw,
  input  logic                     alarm_clear,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [3*DATA_W-1:0]      timer_view,
  output logic                     show_count,
  output logic                     alarm_active,
  output logic                     alarm_pulse
);

  localparam int TMO_W = (ALARM_TIMEOUT > 0) ? $clog2(ALARM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ALARM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ALARM_TIMEOUT > 0) ? ALARM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CONF, RUN, ALARM} state_t;

  state_t state, next_state;
  logic [DATA_W-1:0] bank [N_CH];
  logic [3*DATA_W-1:0] target, elapsed, current;
  logic match, done_q, timeout_hit;
  logic [TMO_W-1:0] tmo_cnt;
  logic show_count_d, alarm_active_d, alarm_pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cs[i])         bank[i] <= count_data[i*DATA_W +: DATA_W];
        else if (!hold[i]) bank[i] <= rtc_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_CH; i++) out_data[i*DATA_W +: DATA_W] = bank[i];
  end

  assign target  = {count_data[TMR_HORA_IDX*DATA_W +: DATA_W],
                    count_data[TMR_MIN_IDX*DATA_W +: DATA_W],
                    count_data[TMR_SEG_IDX*DATA_W +: DATA_W]};
  assign elapsed = {rtc_data[TMR_HORA_IDX*DATA_W +: DATA_W],
                    rtc_data[TMR_MIN_IDX*DATA_W +: DATA_W],
                    rtc_data[TMR_SEG_IDX*DATA_W +: DATA_W]};
  assign current = {bank[TMR_HORA_IDX], bank[TMR_MIN_IDX], bank[TMR_SEG_IDX]};

  // A zero target is treated as "no timer programmed".
  assign match      = (elapsed == target) && (target != '0);
  assign timer_view = show_count ? target : current;
  assign timeout_hit = (ALARM_TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      tmo_cnt      <= '0;
      show_count   <= 1'b1;
      alarm_active <= 1'b0;
      alarm_pulse  <= 1'b0;
    end else begin
      state        <= next_state;
      done_q       <= match && (state == RUN) && !alarm_active;
      show_count   <= show_count_d;
      alarm_active <= alarm_active_d;
      alarm_pulse  <= alarm_pulse_d;
      if (state != ALARM)        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cfg_sw) next_state = CONF;
      CONF:  if (!cfg_sw) next_state = RUN;
      RUN: begin
        if (cfg_sw)      next_state = CONF;
        else if (done_q) next_state = ALARM;
      end
      ALARM: if (alarm_clear || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    show_count_d   = (next_state != RUN);
    alarm_active_d = (next_state == ALARM);
    alarm_pulse_d  = (next_state == ALARM) && (state != ALARM);
  end

endmodule

// File: tb/tb_reg_bank_timer_alarm.sv
// tb/tb_reg_bank_timer_alarm.sv - self-checking bench for reg_bank_timer_alarm
module tb_reg_bank_timer_alarm;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  cs, hold;
  logic [71:0] rtc_data, count_data;
  logic        cfg_sw, alarm_clear;
  logic [71:0] out_data;
  logic [23:0] timer_view;
  logic        show_count, alarm_active, alarm_pulse;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_ch [9];

  reg_bank_timer_alarm #(.ALARM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .hold(hold), .rtc_data(rtc_data),
    .count_data(count_data), .cfg_sw(cfg_sw), .alarm_clear(alarm_clear),
    .out_data(out_data), .timer_view(timer_view), .show_count(show_count),
    .alarm_active(alarm_active), .alarm_pulse(alarm_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] exp_out();
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = exp_ch[i];
    return v;
  endfunction

  function automatic logic [23:0] exp_target();
    return {count_data[64 +: 8], count_data[56 +: 8], count_data[48 +: 8]};
  endfunction

  function automatic logic [23:0] exp_current();
    return {exp_ch[8], exp_ch[7], exp_ch[6]};
  endfunction

  task automatic tick();
    for (int i = 0; i < 9; i++) begin
      if (cs[i])         exp_ch[i] = count_data[i*8 +: 8];
      else if (!hold[i]) exp_ch[i] = rtc_data[i*8 +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_t(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    count_data[64 +: 8] = h; count_data[56 +: 8] = m; count_data[48 +: 8] = s;
  endtask

  task automatic set_e(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    rtc_data[64 +: 8] = h; rtc_data[56 +: 8] = m; rtc_data[48 +: 8] = s;
  endtask

  task automatic go_run();
    cfg_sw = 1'b1; tick();
    cfg_sw = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = '0; hold = '0; cfg_sw = 1'b0; alarm_clear = 1'b0;
    rtc_data = {$urandom, $urandom, $urandom};
    count_data = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 9; i++) exp_ch[i] = 8'h00;
    #12;
    vecs++; if (out_data !== 72'h0) begin errs++; $display("FAIL reset_out got %h want 0", out_data); end
    vecs++; if (show_count !== 1'b1) begin errs++; $display("FAIL reset_show got %b want 1", show_count); end
    vecs++; if (alarm_active !== 1'b0 || alarm_pulse !== 1'b0) begin errs++; $display("FAIL reset_alarm got %b%b want 00", alarm_active, alarm_pulse); end
    vecs++; if (timer_view !== exp_target()) begin errs++; $display("FAIL reset_view got %h want %h", timer_view, exp_target()); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) exp_ch[i] = rtc_data[i*8 +: 8];
  endtask

  task automatic test_bank();
    cs = '0; hold = '0; cs[3] = 1'b1; count_data[24 +: 8] = 8'h15;
    tick();
    vecs++; if (out_data[24 +: 8] !== 8'h15) begin errs++; $display("FAIL bank_load got %h want 15", out_data[24 +: 8]); end
    cs = '0; hold[3] = 1'b1; rtc_data[24 +: 8] = 8'h22;
    tick(); tick();
    vecs++; if (out_data[24 +: 8] !== 8'h15) begin errs++; $display("FAIL bank_hold got %h want 15", out_data[24 +: 8]); end
    hold = '0;
    tick();
    vecs++; if (out_data[24 +: 8] !== 8'h22) begin errs++; $display("FAIL bank_release got %h want 22", out_data[24 +: 8]); end
    for (int n = 0; n < 40; n++) begin
      cs = 9'($urandom); hold = 9'($urandom);
      rtc_data = {$urandom, $urandom, $urandom};
      count_data = {$urandom, $urandom, $urandom};
      tick();
      vecs++; if (out_data !== exp_out()) begin errs++; $display("FAIL bank_rand got %h want %h", out_data, exp_out()); end
    end
    cs = '0; hold = '0;
  endtask

  task automatic test_timer_alarm();
    set_t(8'h00, 8'h01, 8'h30); set_e(8'h99, 8'h99, 8'h99);
    go_run();
    vecs++; if (show_count !== 1'b0) begin errs++; $display("FAIL run_show got %b want 0", show_count); end
    vecs++; if (timer_view !== exp_current()) begin errs++; $display("FAIL run_view got %h want %h", timer_view, exp_current()); end
    set_e(8'h00, 8'h01, 8'h30);
    tick();
    vecs++; if (alarm_active !== 1'b0 || alarm_pulse !== 1'b0) begin errs++; $display("FAIL alarm_early got %b%b want 00", alarm_active, alarm_pulse); end
    tick();
    vecs++; if (alarm_active !== 1'b1 || alarm_pulse !== 1'b1 || show_count !== 1'b1) begin errs++; $display("FAIL alarm_entry got %b%b%b want 111", alarm_active, alarm_pulse, show_count); end
    vecs++; if (timer_view !== exp_target()) begin errs++; $display("FAIL alarm_view got %h want %h", timer_view, exp_target()); end
    tick();
    vecs++; if (alarm_active !== 1'b1 || alarm_pulse !== 1'b0) begin errs++; $display("FAIL alarm_hold got %b%b want 10", alarm_active, alarm_pulse); end
    alarm_clear = 1'b1; set_e(8'h99, 8'h99, 8'h99);
    tick();
    alarm_clear = 1'b0;
    vecs++; if (alarm_active !== 1'b0 || show_count !== 1'b1) begin errs++; $display("FAIL alarm_clear got %b%b want 01", alarm_active, show_count); end
    // Random targets; elapsed differs in one random field before matching.
    for (int n = 0; n < 6; n++) begin
      logic [7:0] h, m, s;
      int f;
      h = 8'($urandom_range(0, 8'h23)); m = 8'($urandom_range(0, 8'h59)); s = 8'($urandom_range(1, 8'h59));
      f = $urandom_range(0, 2);
      set_t(h, m, s);
      set_e(f == 2 ? h ^ 8'h80 : h, f == 1 ? m ^ 8'h80 : m, f == 0 ? s ^ 8'h80 : s);
      go_run();
      tick(); tick(); tick();
      vecs++; if (alarm_active !== 1'b0 || show_count !== 1'b0) begin errs++; $display("FAIL rand_nomatch field %0d got %b%b want 00", f, alarm_active, show_count); end
      set_e(h, m, s);
      tick(); tick();
      vecs++; if (alarm_active !== 1'b1 || alarm_pulse !== 1'b1) begin errs++; $display("FAIL rand_match got %b%b want 11", alarm_active, alarm_pulse); end
      alarm_clear = 1'b1; set_e(8'h99, 8'h99, 8'h99);
      tick();
      alarm_clear = 1'b0;
    end
  endtask

  task automatic test_hour();
    set_t(8'h01, 8'h00, 8'h00); set_e(8'h00, 8'h00, 8'h00);
    go_run();
    for (int n = 0; n < 5; n++) tick();
    vecs++; if (alarm_active !== 1'b0) begin errs++; $display("FAIL hour_nomatch got %b want 0", alarm_active); end
    set_e(8'h01, 8'h00, 8'h00);
    tick(); tick();
    vecs++; if (alarm_active !== 1'b1) begin errs++; $display("FAIL hour_match got %b want 1", alarm_active); end
    alarm_clear = 1'b1; set_e(8'h99, 8'h99, 8'h99);
    tick();
    alarm_clear = 1'b0;
  endtask

  task automatic test_zero_target();
    set_t(8'h00, 8'h00, 8'h00); set_e(8'h00, 8'h00, 8'h00);
    go_run();
    for (int n = 0; n < 100; n++) begin
      tick();
      vecs++; if (alarm_active !== 1'b0 || alarm_pulse !== 1'b0 || show_count !== 1'b0) begin errs++; $display("FAIL zero_target cyc %0d got %b%b%b want 000", n, alarm_active, alarm_pulse, show_count); end
    end
  endtask

  task automatic test_timeout();
    set_t(8'h00, 8'h02, 8'h05); set_e(8'h99, 8'h99, 8'h99);
    go_run();
    set_e(8'h00, 8'h02, 8'h05);
    tick(); tick();
    vecs++; if (alarm_active !== 1'b1) begin errs++; $display("FAIL tmo_entry got %b want 1", alarm_active); end
    set_e(8'h99, 8'h99, 8'h99);
    for (int n = 1; n <= 3; n++) begin
      tick();
      vecs++; if (alarm_active !== 1'b1) begin errs++; $display("FAIL tmo_early cyc %0d got %b want 1", n, alarm_active); end
    end
    tick();
    vecs++; if (alarm_active !== 1'b0 || show_count !== 1'b1) begin errs++; $display("FAIL tmo_expire got %b%b want 01", alarm_active, show_count); end
    alarm_clear = 1'b1;
    tick(); tick();
    alarm_clear = 1'b0;
    vecs++; if (alarm_active !== 1'b0 || show_count !== 1'b1) begin errs++; $display("FAIL clear_in_idle got %b%b want 01", alarm_active, show_count); end
    tick();
    vecs++; if (show_count !== 1'b1) begin errs++; $display("FAIL still_idle got %b want 1", show_count); end
  endtask

  task automatic test_abort();
    set_t(8'h00, 8'h00, 8'h42); set_e(8'h99, 8'h99, 8'h99);
    go_run();
    set_e(8'h00, 8'h00, 8'h42);
    tick();
    vecs++; if (alarm_active !== 1'b0) begin errs++; $display("FAIL abort_pre got %b want 0", alarm_active); end
    cfg_sw = 1'b1;
    tick();
    vecs++; if (alarm_active !== 1'b0 || alarm_pulse !== 1'b0 || show_count !== 1'b1) begin errs++; $display("FAIL abort_conf got %b%b%b want 001", alarm_active, alarm_pulse, show_count); end
    set_e(8'h99, 8'h99, 8'h99);
    tick();
    cfg_sw = 1'b0;
    tick();
    vecs++; if (show_count !== 1'b0 || alarm_active !== 1'b0) begin errs++; $display("FAIL abort_rerun got %b%b want 00", show_count, alarm_active); end
    tick();
    vecs++; if (alarm_active !== 1'b0) begin errs++; $display("FAIL abort_noalarm got %b want 0", alarm_active); end
  endtask

  task automatic test_reset_in_alarm();
    set_e(8'h00, 8'h00, 8'h42);
    tick(); tick();
    vecs++; if (alarm_active !== 1'b1 || alarm_pulse !== 1'b1) begin errs++; $display("FAIL rst_pre got %b%b want 11", alarm_active, alarm_pulse); end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) exp_ch[i] = 8'h00;
    vecs++; if (alarm_active !== 1'b0 || alarm_pulse !== 1'b0 || show_count !== 1'b1) begin errs++; $display("FAIL rst_async got %b%b%b want 001", alarm_active, alarm_pulse, show_count); end
    vecs++; if (out_data !== 72'h0) begin errs++; $display("FAIL rst_async_out got %h want 0", out_data); end
    #2 reset = 1'b0;
    set_e(8'h99, 8'h99, 8'h99);
    tick();
    vecs++; if (out_data !== exp_out() || show_count !== 1'b1) begin errs++; $display("FAIL rst_after got %h/%b want %h/1", out_data, show_count, exp_out()); end
  endtask

  initial begin
    test_reset();
    test_bank();
    test_timer_alarm();
    test_hour();
    test_zero_target();
    test_timeout();
    test_abort();
    test_reset_in_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
